// File: rtl/pipe_ctrl.sv
// pipe_ctrl: interlock controller for an in-order pipeline without forwarding.
// Tracks the destinations held in pipes 4..6, stalls the front end on a
// read-after-write hazard, freezes pipe 4 while a multi-cycle divide runs,
// and flushes pipes 2..4 on a taken redirect from pipe 5.
//
// Ports
//   clk, nrst              core clock, asynchronous active-low reset
//   valid3                 pipe 3 holds a valid instruction
//   rs1_3/rs2_3            pipe 3 source registers
//   use_rs1_3/use_rs2_3    pipe 3 reads the corresponding source
//   rd3, we3               pipe 3 destination and write enable
//   div3                   pipe 3 instruction is a multi-cycle divide/remainder
//   redirect5              taken branch/jump in pipe 5
//   hold_fe                freeze pc, pipe 2 and pipe 3
//   hold_is                freeze pipe 4
//   bubble4 / bubble5      load a NOP into pipe 4 / pipe 5
//   flush                  load NOPs into pipes 2, 3 and 4
//   div_busy               registered, high while the divide occupies pipe 4
//   stall_cnt, flush_cnt   saturating counts of hold_fe / flush cycles
module pipe_ctrl #(
  parameter int DIV_LAT = 32
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        valid3,
  input  logic [4:0]  rs1_3,
  input  logic [4:0]  rs2_3,
  input  logic        use_rs1_3,
  input  logic        use_rs2_3,
  input  logic [4:0]  rd3,
  input  logic        we3,
  input  logic        div3,
  input  logic        redirect5,
  output logic        hold_fe,
  output logic        hold_is,
  output logic        bubble4,
  output logic        bubble5,
  output logic        flush,
  output logic        div_busy,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  localparam int CNT_W = $clog2(DIV_LAT);

  typedef enum logic {S_RUN, S_DIV} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;

  // Tracking entries for pipes 4..6. Only pipe 4 needs the divide flag.
  logic       r_t4_v, r_t4_we, r_t4_div;
  logic [4:0] r_t4_rd;
  logic       r_t5_v, r_t5_we;
  logic [4:0] r_t5_rd;
  logic       r_t6_v, r_t6_we;
  logic [4:0] r_t6_rd;

  logic w_hit1, w_hit2, w_hazard, w_div_active, w_issue;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic hit(input logic [4:0] r, input logic v,
                               input logic we, input logic [4:0] rd);
    return v & we & (rd == r) & (r != 5'd0);
  endfunction

  always_comb begin
    w_hit1 = hit(rs1_3, r_t4_v, r_t4_we, r_t4_rd) |
             hit(rs1_3, r_t5_v, r_t5_we, r_t5_rd) |
             hit(rs1_3, r_t6_v, r_t6_we, r_t6_rd);
    w_hit2 = hit(rs2_3, r_t4_v, r_t4_we, r_t4_rd) |
             hit(rs2_3, r_t5_v, r_t5_we, r_t5_rd) |
             hit(rs2_3, r_t6_v, r_t6_we, r_t6_rd);
    w_hazard = valid3 & ((use_rs1_3 & w_hit1) | (use_rs2_3 & w_hit2));
    // The divide flag in T4 guards against a DIV state with no divide behind it.
    w_div_active = (r_state == S_DIV) & r_t4_div;
    w_issue = ~redirect5 & ~w_div_active & ~w_hazard;

    hold_fe = ~redirect5 & (w_div_active | w_hazard);
    hold_is = ~redirect5 & w_div_active;
    bubble4 = ~redirect5 & ~w_div_active & w_hazard;
    bubble5 = ~redirect5 & w_div_active;
    flush   = redirect5;
  end

  // Control state: FSM, divide counter, entry valids, perf counters
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= S_RUN;
      r_cnt     <= '0;
      div_busy  <= 1'b0;
      r_t4_v    <= 1'b0;
      r_t4_we   <= 1'b0;
      r_t4_div  <= 1'b0;
      r_t5_v    <= 1'b0;
      r_t5_we   <= 1'b0;
      r_t6_v    <= 1'b0;
      r_t6_we   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      r_t6_v  <= r_t5_v;
      r_t6_we <= r_t5_we;
      if (hold_fe) stall_cnt <= sat_inc(stall_cnt);
      if (flush)   flush_cnt <= sat_inc(flush_cnt);

      if (redirect5) begin
        r_t4_v   <= 1'b0;
        r_t4_we  <= 1'b0;
        r_t4_div <= 1'b0;
        r_t5_v   <= 1'b0;
        r_t5_we  <= 1'b0;
        r_cnt    <= '0;
        r_state  <= S_RUN;
        div_busy <= 1'b0;
      end else if (w_div_active) begin
        // T4 keeps the divide; pipe 5 receives bubbles.
        r_t5_v  <= 1'b0;
        r_t5_we <= 1'b0;
        r_cnt   <= r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          r_state  <= S_RUN;
          div_busy <= 1'b0;
        end
      end else begin
        r_t5_v  <= r_t4_v;
        r_t5_we <= r_t4_we;
        if (w_hazard) begin
          r_t4_v   <= 1'b0;
          r_t4_we  <= 1'b0;
          r_t4_div <= 1'b0;
          r_state  <= S_RUN;
          div_busy <= 1'b0;
        end else begin
          r_t4_v   <= valid3;
          r_t4_we  <= valid3 & we3 & (rd3 != 5'd0);
          r_t4_div <= valid3 & div3;
          if (valid3 & div3) begin
            r_state  <= S_DIV;
            r_cnt    <= CNT_W'(DIV_LAT - 1);
            div_busy <= 1'b1;
          end else begin
            r_state  <= S_RUN;
            div_busy <= 1'b0;
          end
        end
      end
    end
  end

  // Destination addresses: meaningful only where the matching valid is set
  always_ff @(posedge clk) begin
    r_t6_rd <= r_t5_rd;
    if (!w_div_active) r_t5_rd <= r_t4_rd;
    if (w_issue)       r_t4_rd <= rd3;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios followed by random traffic. The
// driver computes the expected outputs of each cycle from a pipeline-slot
// reference model and queues them; a monitor on the falling edge pops and
// compares against the DUT.
module tb_pipe_ctrl;
  localparam int DL = 32;

  logic        clk = 1'b0;
  logic        nrst;
  logic        valid3, use_rs1_3, use_rs2_3, we3, div3, redirect5;
  logic [4:0]  rs1_3, rs2_3, rd3;
  logic        hold_fe, hold_is, bubble4, bubble5, flush, div_busy;
  logic [31:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_errors = 0;

  pipe_ctrl #(.DIV_LAT(DL)) dut (
    .clk(clk), .nrst(nrst), .valid3(valid3),
    .rs1_3(rs1_3), .rs2_3(rs2_3), .use_rs1_3(use_rs1_3), .use_rs2_3(use_rs2_3),
    .rd3(rd3), .we3(we3), .div3(div3), .redirect5(redirect5),
    .hold_fe(hold_fe), .hold_is(hold_is), .bubble4(bubble4), .bubble5(bubble5),
    .flush(flush), .div_busy(div_busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic v; logic we; logic [4:0] rd; } ins_t;
  typedef struct packed {
    logic hfe, his, b4, b5, fl, busy;
    logic [31:0] sc, fc;
  } exp_t;

  exp_t        exp_q[$];
  ins_t        m_pipe[3];      // index 0 = pipe 4, 1 = pipe 5, 2 = pipe 6
  int          m_age;          // cycles the divide has spent in pipe 4, 0 = none
  logic [31:0] m_stall, m_flush;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) m_pipe[k] = '0;
    m_age   = 0;
    m_stall = '0;
    m_flush = '0;
  endfunction

  function automatic bit m_hit(input logic [4:0] r);
    bit h = 1'b0;
    for (int k = 0; k < 3; k++)
      if (r != 5'd0 && m_pipe[k].v && m_pipe[k].we && m_pipe[k].rd == r) h = 1'b1;
    return h;
  endfunction

  task automatic cycle(input logic iv, input logic [4:0] ir1, input logic iu1,
                       input logic [4:0] ir2, input logic iu2, input logic [4:0] ird,
                       input logic iwe, input logic idv, input logic irdr, input logic irst);
    exp_t e;
    bit   div_hold, haz;
    @(posedge clk);
    #1;
    valid3 = iv; rs1_3 = ir1; use_rs1_3 = iu1; rs2_3 = ir2; use_rs2_3 = iu2;
    rd3 = ird; we3 = iwe; div3 = idv; redirect5 = irdr; nrst = ~irst;
    if (irst) model_reset();
    div_hold = (m_age > 0) && (m_age < DL);
    haz      = iv && ((iu1 && m_hit(ir1)) || (iu2 && m_hit(ir2)));
    e.hfe  = !irdr && (div_hold || haz);
    e.his  = !irdr && div_hold;
    e.b4   = !irdr && !div_hold && haz;
    e.b5   = !irdr && div_hold;
    e.fl   = irdr;
    e.busy = div_hold;
    e.sc   = m_stall;
    e.fc   = m_flush;
    exp_q.push_back(e);
    if (!irst) begin
      if (e.hfe && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (e.fl && m_flush != 32'hFFFF_FFFF) m_flush++;
      m_pipe[2] = m_pipe[1];
      if (irdr) begin
        m_pipe[1] = '0; m_pipe[0] = '0; m_age = 0;
      end else if (div_hold) begin
        m_pipe[1] = '0; m_age++;
      end else if (haz) begin
        m_pipe[1] = m_pipe[0]; m_pipe[0] = '0; m_age = 0;
      end else begin
        m_pipe[1] = m_pipe[0];
        m_pipe[0].v = iv; m_pipe[0].we = iwe; m_pipe[0].rd = ird;
        m_age = (iv && idv) ? 1 : 0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("hold_fe",   32'(hold_fe),  32'(e.hfe));
        chk("hold_is",   32'(hold_is),  32'(e.his));
        chk("bubble4",   32'(bubble4),  32'(e.b4));
        chk("bubble5",   32'(bubble5),  32'(e.b5));
        chk("flush",     32'(flush),    32'(e.fl));
        chk("div_busy",  32'(div_busy), 32'(e.busy));
        chk("stall_cnt", stall_cnt, e.sc);
        chk("flush_cnt", flush_cnt, e.fc);
      end
    end
  end

  initial begin : driver
    logic [31:0] s0, f0;
    int n, busy_n, his_n, b5_n;
    bit done;
    nrst = 1'b0; valid3 = 0; rs1_3 = 0; rs2_3 = 0; use_rs1_3 = 0; use_rs2_3 = 0;
    rd3 = 0; we3 = 0; div3 = 0; redirect5 = 0;
    model_reset();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // RAW on rd=5: three stall cycles, issue on the fourth
    cycle(1, 0, 0, 0, 0, 5'd5, 1, 0, 0, 0);
    #1 s0 = stall_cnt;
    n = 0; done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      cycle(1, 5'd5, 1, 0, 0, 0, 0, 0, 0, 0);
      #1;
      if (hold_fe) n++; else done = 1;
    end
    chk("raw_stall_cycles", 32'(n), 32'd3);
    chk("raw_stall_cnt", stall_cnt - s0, 32'd3);

    // Writes to x0 never create a hazard
    cycle(1, 0, 0, 0, 0, 5'd0, 1, 0, 0, 0);
    #1 s0 = stall_cnt;
    cycle(1, 5'd0, 1, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("rd0_no_stall", 32'(hold_fe), 32'd0);
    idle(1);
    #1 chk("rd0_stall_cnt", stall_cnt, s0);

    // Divide: busy DL-1 cycles, consumer of its result waits it out
    idle(3);
    cycle(1, 0, 0, 0, 0, 5'd7, 1, 1, 0, 0);
    busy_n = 0; his_n = 0; b5_n = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(1, 5'd7, 1, 0, 0, 0, 0, 0, 0, 0);
      #1;
      busy_n += int'(div_busy); his_n += int'(hold_is); b5_n += int'(bubble5);
    end
    chk("div_busy_cycles", 32'(busy_n), 32'(DL - 1));
    chk("div_hold_is_cycles", 32'(his_n), 32'(DL - 1));
    chk("div_bubble5_cycles", 32'(b5_n), 32'(DL - 1));
    chk("div_done_busy", 32'(div_busy), 32'd0);

    // Redirect wins over a pending hazard
    idle(3);
    cycle(1, 0, 0, 0, 0, 5'd9, 1, 0, 0, 0);
    #1 f0 = flush_cnt;
    cycle(1, 5'd9, 1, 0, 0, 0, 0, 0, 1, 0);
    #1;
    chk("redir_flush", 32'(flush), 32'd1);
    chk("redir_hold_fe", 32'(hold_fe), 32'd0);
    chk("redir_bubble4", 32'(bubble4), 32'd0);
    cycle(1, 5'd9, 1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("redir_no_stale_stall", 32'(hold_fe), 32'd0);
    chk("redir_flush_cnt", flush_cnt - f0, 32'd1);

    // Redirect on the first divide cycle aborts the divide
    idle(3);
    cycle(1, 0, 0, 0, 0, 5'd4, 1, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    #1;
    chk("divabort_flush", 32'(flush), 32'd1);
    chk("divabort_hold_is", 32'(hold_is), 32'd0);
    cycle(1, 5'd4, 1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("divabort_busy", 32'(div_busy), 32'd0);
    chk("divabort_hold_fe", 32'(hold_fe), 32'd0);

    // Reset in the middle of a divide
    idle(3);
    cycle(1, 0, 0, 0, 0, 5'd6, 1, 1, 0, 0);
    idle(21);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    chk("rst_hold_fe", 32'(hold_fe), 32'd0);
    chk("rst_hold_is", 32'(hold_is), 32'd0);
    chk("rst_busy", 32'(div_busy), 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_flush_cnt", flush_cnt, 32'd0);
    idle(1);
    #1 chk("rst_release_hold", 32'(hold_fe), 32'd0);
    cycle(1, 0, 0, 0, 0, 5'd3, 1, 0, 0, 0);
    cycle(1, 5'd3, 1, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("rst_then_raw", 32'(hold_fe), 32'd1);

    // Random traffic with a narrow register range to provoke hazards
    for (int i = 0; i < 2000; i++) begin
      cycle($urandom_range(0, 3) != 0,
            5'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 11) == 0,
            $urandom_range(0, 299) == 0);
    end

    repeat (2) @(negedge clk);
    #1 chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
